// File: rtl/matrix_drive_pkg.sv
// rtl/matrix_drive_pkg.sv - shared types, bridge codes and index helpers for the matrix scanner
package matrix_drive_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        DEAD,
        DRIVE,
        DONE
    } state_t;

    localparam logic [1:0] BR_OFF = 2'b00;
    localparam logic [1:0] BR_LO  = 2'b01;
    localparam logic [1:0] BR_HI  = 2'b10;

    // Width of a cell index; a single-cell matrix still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Cells are numbered row-major: index = row*cols + col.
    function automatic int row_of(input int idx, input int cols);
        return idx / cols;
    endfunction

    function automatic int col_of(input int idx, input int cols);
        return idx % cols;
    endfunction

endpackage

// File: rtl/matrix_drive_scanner_hbridge_pair_encode.sv
// rtl/matrix_drive_scanner_hbridge_pair_encode.sv - {hi,lo} H-bridge pair encoder that cannot produce 2'b11
module hbridge_pair_encode
    import matrix_drive_pkg::*;
(
    input  logic       active,
    input  logic       polarity,
    output logic [1:0] pair
);

    // Only one of the three legal codes can ever be selected.
    assign pair = active ? (polarity ? BR_HI : BR_LO) : BR_OFF;

endmodule

// File: rtl/matrix_drive_scanner.sv
// rtl/matrix_drive_scanner.sv - ROWS x COLS actuator matrix scanner with dead time, pulse width and differential update
module matrix_drive_scanner
    import matrix_drive_pkg::*;
#(
    parameter int ROWS  = 5,
    parameter int COLS  = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ROWS*COLS-1:0] cells_state,
    input  logic [CNT_W-1:0]     pulse_width,
    input  logic [CNT_W-1:0]     dead_time,
    input  logic                 cell_invert,
    input  logic                 diff_mode,
    output logic [ROWS-1:0]      rows,
    output logic [COLS-1:0]      cols,
    output logic [ROWS-1:0]      rows_enable,
    output logic [COLS-1:0]      cols_enable,
    output logic [2*ROWS-1:0]    rows_hbridge,
    output logic [2*COLS-1:0]    cols_hbridge,
    output logic                 busy,
    output logic                 update_done
);

    localparam int N     = ROWS * COLS;
    localparam int IDX_W = idx_width(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  pw_q, dt_q;
    logic [N-1:0]      tgt_q, shadow_q;
    logic              diff_q;
    logic              load, commit, skip, last, cur_tgt;

    logic              sel_on;
    logic [ROWS-1:0]   sel_row, row_act;
    logic [COLS-1:0]   sel_col, col_act;
    logic [2*ROWS-1:0] row_pair;
    logic [2*COLS-1:0] col_pair;

    assign cur_tgt = tgt_q[idx_q];
    assign last    = (idx_q == LAST_IDX);
    // A zero pulse width would drive nothing, so it is treated like an unchanged cell.
    assign skip    = (diff_q && (tgt_q[idx_q] == shadow_q[idx_q])) || (pw_q == '0);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, index/counter update and latch/commit strobes.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (skip) begin
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (dt_q != '0) begin
                    state_d = DEAD;
                    cnt_d   = dt_q - CNT_W'(1);
                end else begin
                    state_d = DRIVE;
                    cnt_d   = pw_q - CNT_W'(1);
                end
            end
            DEAD: begin
                if (cnt_q == '0) begin
                    state_d = DRIVE;
                    cnt_d   = pw_q - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    commit = 1'b1;
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = SETUP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Abort wins over everything, including a same-cycle start and a final-cycle commit.
        if (abort) begin
            state_d = IDLE;
            idx_d   = '0;
            load    = 1'b0;
            commit  = 1'b0;
        end
    end

    // Scan datapath: index, counter, latched settings, target and shadow.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q    <= '0;
            cnt_q    <= '0;
            pw_q     <= '0;
            dt_q     <= '0;
            diff_q   <= 1'b0;
            tgt_q    <= '0;
            shadow_q <= '0;
        end else begin
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            if (load) begin
                tgt_q  <= cells_state ^ {N{cell_invert}};
                pw_q   <= pulse_width;
                dt_q   <= dead_time;
                diff_q <= diff_mode;
            end
            if (commit) begin
                shadow_q[idx_q] <= tgt_q[idx_q];
            end
        end
    end

    // One-hot row/column decode of the current cell.
    always_comb begin
        sel_row = '0;
        sel_col = '0;
        sel_on  = (state_q == SETUP) || (state_q == DEAD) || (state_q == DRIVE);
        for (int r = 0; r < ROWS; r++) begin
            sel_row[r] = (row_of(int'(idx_q), COLS) == r);
        end
        for (int c = 0; c < COLS; c++) begin
            sel_col[c] = (col_of(int'(idx_q), COLS) == c);
        end
    end

    assign row_act = (state_q == DRIVE) ? sel_row : '0;
    assign col_act = (state_q == DRIVE) ? sel_col : '0;

    // Row drives hi for a set target; the column takes the opposite leg.
    for (genvar g = 0; g < ROWS; g++) begin : g_row
        hbridge_pair_encode u_enc (
            .active   (row_act[g]),
            .polarity (cur_tgt),
            .pair     (row_pair[2*g+1:2*g])
        );
    end

    for (genvar g = 0; g < COLS; g++) begin : g_col
        hbridge_pair_encode u_enc (
            .active   (col_act[g]),
            .polarity (~cur_tgt),
            .pair     (col_pair[2*g+1:2*g])
        );
    end

    // Registered pad outputs; abort blanks them on the very next cycle.
    always_ff @(posedge clock) begin
        if (reset || abort) begin
            rows         <= '0;
            cols         <= '0;
            rows_enable  <= '0;
            cols_enable  <= '0;
            rows_hbridge <= '0;
            cols_hbridge <= '0;
            busy         <= 1'b0;
            update_done  <= 1'b0;
        end else begin
            rows         <= sel_on ? sel_row : '0;
            cols         <= sel_on ? sel_col : '0;
            rows_enable  <= row_act;
            cols_enable  <= col_act;
            rows_hbridge <= row_pair;
            cols_hbridge <= col_pair;
            busy         <= (state_q != IDLE);
            update_done  <= (state_q == DONE);
        end
    end

endmodule

// File: tb/tb_matrix_drive_scanner.sv
// tb/tb_matrix_drive_scanner.sv - scoreboard bench for matrix_drive_scanner on a 2x2 matrix
module tb_matrix_drive_scanner;

    localparam int ROWS  = 2;
    localparam int COLS  = 2;
    localparam int CNT_W = 16;
    localparam int N     = ROWS * COLS;

    logic              clock = 1'b0;
    logic              reset, start, abort;
    logic [N-1:0]      cells_state;
    logic [CNT_W-1:0]  pulse_width, dead_time;
    logic              cell_invert, diff_mode;
    logic [ROWS-1:0]   rows, rows_enable;
    logic [COLS-1:0]   cols, cols_enable;
    logic [2*ROWS-1:0] rows_hbridge;
    logic [2*COLS-1:0] cols_hbridge;
    logic              busy, update_done;

    matrix_drive_scanner #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .cells_state  (cells_state),
        .pulse_width  (pulse_width),
        .dead_time    (dead_time),
        .cell_invert  (cell_invert),
        .diff_mode    (diff_mode),
        .rows         (rows),
        .cols         (cols),
        .rows_enable  (rows_enable),
        .cols_enable  (cols_enable),
        .rows_hbridge (rows_hbridge),
        .cols_hbridge (cols_hbridge),
        .busy         (busy),
        .update_done  (update_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] r;
        logic [1:0] c;
        logic [3:0] rh;
        logic [3:0] ch;
        int         len;
    } drv_t;

    drv_t drv_q[$];
    int   done_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   start_cyc = 0;
    logic mon_en   = 1'b0;
    logic in_win   = 1'b0;
    logic prev_done = 1'b0;
    drv_t win;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_drv(input logic [1:0] r, input logic [1:0] c,
                           input logic [3:0] rh, input logic [3:0] ch, input int len);
        drv_t d;
        d.r = r; d.c = c; d.rh = rh; d.ch = ch; d.len = len;
        drv_q.push_back(d);
    endtask

    task automatic start_scan(input logic [3:0] cells, input logic inv, input logic diff,
                              input logic [15:0] dt, input logic [15:0] pw, input int done_lat);
        @(negedge clock);
        cells_state = cells;
        cell_invert = inv;
        diff_mode   = diff;
        dead_time   = dt;
        pulse_width = pw;
        start       = 1'b1;
        start_cyc   = cyc + 1;
        if (done_lat >= 0) done_q.push_back(done_lat);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (done_q.size() == 0 && !busy && !in_win) break;
            @(negedge clock);
        end
        repeat (2) @(negedge clock);
        chk("done_queue_empty", 32'(done_q.size()), 32'd0);
        chk("drive_queue_empty", 32'(drv_q.size()), 32'd0);
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: safety invariants every cycle, drive windows and completion popped from the scoreboard.
    always @(negedge clock) begin
        if (mon_en) begin
            logic ok;
            drv_t e;
            ok = 1'b1;
            for (int r = 0; r < ROWS; r++) begin
                if (rows_hbridge[2*r +: 2] == 2'b11) ok = 1'b0;
                if ((rows_hbridge[2*r +: 2] != 2'b00) != rows_enable[r]) ok = 1'b0;
            end
            for (int c = 0; c < COLS; c++) begin
                if (cols_hbridge[2*c +: 2] == 2'b11) ok = 1'b0;
                if ((cols_hbridge[2*c +: 2] != 2'b00) != cols_enable[c]) ok = 1'b0;
            end
            if (!busy && ((|rows) || (|cols) || (|rows_enable) || (|cols_enable) ||
                          (|rows_hbridge) || (|cols_hbridge) || update_done)) ok = 1'b0;
            chk("bridge_invariant", 32'(ok), 32'd1);

            if ((|rows_enable) || (|cols_enable)) begin
                if (!in_win) begin
                    in_win = 1'b1;
                    win.r  = rows_enable;
                    win.c  = cols_enable;
                    win.rh = rows_hbridge;
                    win.ch = cols_hbridge;
                    win.len = 0;
                    chk("select_matches_enable", 32'({rows, cols}), 32'({rows_enable, cols_enable}));
                end
                win.len++;
            end else if (in_win) begin
                in_win = 1'b0;
                if (drv_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL drive_unexpected: got window rows_en=%b cols_en=%b expected none", win.r, win.c);
                end else begin
                    e = drv_q.pop_front();
                    chk("drive_rows_enable", 32'(win.r), 32'(e.r));
                    chk("drive_cols_enable", 32'(win.c), 32'(e.c));
                    chk("drive_rows_hbridge", 32'(win.rh), 32'(e.rh));
                    chk("drive_cols_hbridge", 32'(win.ch), 32'(e.ch));
                    chk("drive_length", 32'(win.len), 32'(e.len));
                end
            end

            if (prev_done) chk("busy_after_done", 32'(busy), 32'd0);
            prev_done = update_done;
            if (update_done) begin
                if (done_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL done_unexpected: got update_done at cycle %0d expected none", cyc - start_cyc);
                end else begin
                    chk("done_latency", 32'(cyc - start_cyc), 32'(done_q.pop_front()));
                    chk("busy_at_done", 32'(busy), 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        cells_state = '0; pulse_width = '0; dead_time = '0;
        cell_invert = 1'b0; diff_mode = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_outputs", 32'({rows, cols, rows_enable, cols_enable, rows_hbridge,
                                 cols_hbridge, busy, update_done}), 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;

        // Full scan, alternating polarity.
        exp_drv(2'b01, 2'b01, 4'b0010, 4'b0001, 3);
        exp_drv(2'b01, 2'b10, 4'b0001, 4'b1000, 3);
        exp_drv(2'b10, 2'b01, 4'b1000, 4'b0001, 3);
        exp_drv(2'b10, 2'b10, 4'b0100, 4'b1000, 3);
        start_scan(4'b0101, 1'b0, 1'b0, 16'd2, 16'd3, 25);
        wait_idle();

        // Same cells in differential mode: nothing to drive.
        start_scan(4'b0101, 1'b0, 1'b1, 16'd2, 16'd3, 5);
        wait_idle();

        // Only cell 1 changed.
        exp_drv(2'b01, 2'b10, 4'b0010, 4'b0100, 3);
        start_scan(4'b0111, 1'b0, 1'b1, 16'd2, 16'd3, 10);
        wait_idle();

        // Inverted all-zero target drives every cell set.
        exp_drv(2'b01, 2'b01, 4'b0010, 4'b0001, 3);
        exp_drv(2'b01, 2'b10, 4'b0010, 4'b0100, 3);
        exp_drv(2'b10, 2'b01, 4'b1000, 4'b0001, 3);
        exp_drv(2'b10, 2'b10, 4'b1000, 4'b0100, 3);
        start_scan(4'b0000, 1'b1, 1'b0, 16'd2, 16'd3, 25);
        wait_idle();

        // Abort on the same cycle as start: the request is dropped.
        @(negedge clock);
        cells_state = 4'b1111; start = 1'b1; abort = 1'b1;
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clock);
        chk("abort_with_start_busy", 32'(busy), 32'd0);

        // Abort in the second DRIVE cycle of cell 2; a mid-scan start and input changes are ignored.
        exp_drv(2'b01, 2'b01, 4'b0001, 4'b0010, 3);
        exp_drv(2'b01, 2'b10, 4'b0001, 4'b1000, 3);
        exp_drv(2'b10, 2'b01, 4'b0100, 4'b0010, 1);
        start_scan(4'b0000, 1'b0, 1'b0, 16'd2, 16'd3, -1);
        repeat (4) @(negedge clock);
        cells_state = 4'b1010; pulse_width = 16'd1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (11) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("abort_outputs", 32'({rows, cols, rows_enable, cols_enable, rows_hbridge,
                                 cols_hbridge, busy, update_done}), 32'd0);
        wait_idle();

        // Shadow now 1100: differential all-zero scan drives only cells 2 and 3.
        exp_drv(2'b10, 2'b01, 4'b0100, 4'b0010, 3);
        exp_drv(2'b10, 2'b10, 4'b0100, 4'b1000, 3);
        start_scan(4'b0000, 1'b0, 1'b1, 16'd2, 16'd3, 15);
        wait_idle();

        // Zero pulse width skips every cell.
        start_scan(4'b1111, 1'b0, 1'b0, 16'd2, 16'd0, 5);
        wait_idle();

        // Zero dead time goes straight from SETUP to DRIVE.
        exp_drv(2'b01, 2'b01, 4'b0010, 4'b0001, 2);
        exp_drv(2'b01, 2'b10, 4'b0010, 4'b0100, 2);
        exp_drv(2'b10, 2'b01, 4'b1000, 4'b0001, 2);
        exp_drv(2'b10, 2'b10, 4'b1000, 4'b0100, 2);
        start_scan(4'b1111, 1'b0, 1'b1, 16'd0, 16'd2, 13);
        wait_idle();

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
